mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers. It supersedes the fixed-width multiplier clocked from a separate fast clock: it runs on the core clock and uses a start/busy/done handshake, so the main control can stall instead of relying on clock ratios. It sits beside the ALU. Its results feed MFHI/MFLO, and its divide-by-zero flag feeds exception handling.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mul_div_unit.sv | 151 +++++++++++++++
 tb/tb_mul_div_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO (shift-add multiply, restoring divide).
// Latency: WIDTH+1 edges start->done; divide-by-zero reports after 1 edge.
// Backpressure: busy high while working; start only accepted in IDLE, core stalls on busy.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic [WIDTH:0]     mul_sum, div_shl, div_diff;
    logic               start_signed;

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shl  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_shl - {1'b0, opb_q};
    assign start_signed = ~op[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op[1] && b == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(WIDTH);
                        op_d    = op;
                        sa_d    = start_signed & a[WIDTH-1];
                        sb_d    = start_signed & b[WIDTH-1];
                        acc_d   = {{WIDTH{1'b0}}, cneg(a, start_signed & a[WIDTH-1])};
                        opb_d   = cneg(b, start_signed & b[WIDTH-1]);
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    acc_d = div_diff[WIDTH]
                          ? {div_shl[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0}
                          : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                // Unsigned ops record zero signs, so correction is a no-op for them.
                if (op_q[1]) begin
                    lo_d = cneg(acc_q[WIDTH-1:0], sa_q ^ sb_q);
                    hi_d = cneg(acc_q[2*WIDTH-1:WIDTH], sa_q);
                end else begin
                    {hi_d, lo_d} = cneg2(acc_q, sa_q ^ sb_q);
                end
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            op_q    <= OP_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic HI/LO model.
// Latency: checks done timing, busy length and one-cycle pulses.
// Backpressure: exercises ignored start/mthi/mtlo while not idle.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit host arithmetic; SV division truncates toward zero.
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint      sx, sy, r;
        logic [63:0] u;
        dz = 1'b0;
        h  = m_hi;
        l  = m_lo;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_MULT: begin
                r = sx * sy;
                h = r[63:32];
                l = r[31:0];
            end
            OP_MULTU: begin
                u = {32'd0, x} * {32'd0, y};
                h = u[63:32];
                l = u[31:0];
            end
            OP_DIV: begin
                if (y == '0) dz = 1'b1;
                else begin
                    r = sx / sy;
                    l = r[31:0];
                    r = sx % sy;
                    h = r[31:0];
                end
            end
            default: begin
                if (y == '0) dz = 1'b1;
                else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic with_mtlo, input int inj);
        logic [W-1:0] eh, el;
        logic         edz;
        int           n, bcnt;
        model(o, x, y, eh, el, edz);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; mtlo = with_mtlo; wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        n = 0;
        bcnt = 0;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            start = (n + 1 == inj);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", n, edz ? 0 : W + 1);
        check("busy_cycles", bcnt, edz ? 0 : W + 1);
        check("div_zero", 32'(div_zero), 32'(edz));
        check("busy_at_done", 32'(busy), 32'd0);
        check("hi", hi, eh);
        check("lo", lo, el);
        m_hi = eh;
        m_lo = el;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("dz_pulse", 32'(div_zero), 32'd0);
    endtask

    task automatic write_hilo(input logic h, input logic l, input logic [W-1:0] v);
        @(negedge clk);
        mthi = h; mtlo = l; wdata = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; wdata = $urandom;
        if (h) m_hi = v;
        if (l) m_lo = v;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic         saw_done;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b1;

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, -1);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, -1);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);

        write_hilo(1'b1, 1'b0, 32'h0000_1234);
        write_hilo(1'b0, 1'b1, 32'hCAFE_0001);
        do_op(OP_DIVU, 32'd5, 32'd0, 1'b0, -1);
        do_op(OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0, -1);
        write_hilo(1'b1, 1'b1, 32'h5A5A_A5A5);

        do_op(OP_MULTU, 32'h0001_0003, 32'h0000_0100, 1'b1, -1);
        do_op(OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0, 5);

        // Abort a MULT with reset mid-run.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd1234; b = 32'hFFFF_0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = '0;
                1: y = 32'($urandom_range(1, 9));
                2: x = 32'h8000_0000;
                3: y = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(2'($urandom), x, y, 1'($urandom), ($urandom_range(0, 3) == 0) ? 7 : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
